// File: rtl/dti_uart_pkg.sv
// Shared types and constants for the dti_uart receive path.
package dti_uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;

  localparam int RX_DATA_W = 9;

  localparam logic [3:0] DATA_BITS_MIN = 4'd5;
  localparam logic [3:0] DATA_BITS_MAX = 4'd9;
  localparam logic [3:0] DATA_BITS_DEF = 4'd8;

  typedef struct packed {
    logic [RX_DATA_W-1:0] data;
    logic                 parity_err;
    logic                 frame_err;
  } rx_entry_t;

  function automatic logic [3:0] clamp_data_bits(input logic [3:0] bits);
    return ((bits < DATA_BITS_MIN) || (bits > DATA_BITS_MAX)) ? DATA_BITS_DEF : bits;
  endfunction

endpackage

// File: rtl/dti_uart_sync_fifo.sv
// Generic show-ahead FIFO: the head entry is visible on rdata_o whenever it is not empty.
// rdata_o reads as zero while empty so downstream sees clean values after reset.
module dti_uart_sync_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  // A push into a full FIFO is still accepted when the head leaves in the same cycle.
  assign do_pop  = pop_i && (level_q != '0);
  assign do_push = push_i && ((level_q != LW'(DEPTH)) || do_pop);

  always_comb begin
    level_d = level_q;
    if (do_push && !do_pop) begin
      level_d = level_q + LW'(1);
    end else if (do_pop && !do_push) begin
      level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LW'(DEPTH));
  assign level_o = level_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/dti_uart_rx_core.sv
// Buffered UART receiver: oversampled frame FSM feeding a show-ahead FIFO with overrun and RTS.
// Define DTI_UART_RX_BREAK_DET_EN to swallow break frames and flag them on break_det.
module dti_uart_rx_core
  import dti_uart_pkg::*;
#(
  parameter int MAX_DATA_BITS = 9,
  parameter int FIFO_DEPTH    = 16,
  parameter int OVERSAMPLE    = 16,
  parameter int DIV_W         = 16,
  parameter int RTS_THRESH    = 12
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx,
  input  logic [DIV_W-1:0]              cfg_div,
  input  logic [3:0]                    cfg_data_bits,
  input  logic                          cfg_stop2,
  input  logic                          cfg_parity_en,
  input  logic                          cfg_parity_odd,
  input  logic                          rd_en,
  input  logic                          clr_overrun,
  output logic [MAX_DATA_BITS-1:0]      rd_data,
  output logic                          rd_parity_err,
  output logic                          rd_frame_err,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overrun,
  output logic                          break_det,
  output logic                          rts_n
);

`ifdef DTI_UART_RX_BREAK_DET_EN
  localparam bit BREAK_EN = 1'b1;
`else
  localparam bit BREAK_EN = 1'b0;
`endif

  localparam int              SC_W     = $clog2(OVERSAMPLE);
  localparam logic [SC_W-1:0] MID_CNT  = SC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SC_W-1:0] LAST_CNT = SC_W'(OVERSAMPLE - 1);
  localparam int              LW       = $clog2(FIFO_DEPTH) + 1;

  logic                     rx_meta_q, rx_s_q;
  logic [DIV_W-1:0]         div_cnt_q;
  logic                     tick;

  rx_state_e                state_q, state_d;
  logic [SC_W-1:0]          s_cnt_q, s_cnt_d;
  logic [3:0]               bit_cnt_q, bit_cnt_d;
  logic [3:0]               nbits_q, nbits_d;
  logic [MAX_DATA_BITS-1:0] shift_q, shift_d;
  logic [MAX_DATA_BITS-1:0] aligned;
  logic                     stop2_q, stop2_d;
  logic                     par_en_q, par_en_d;
  logic                     par_odd_q, par_odd_d;
  logic                     par_bit_q, par_bit_d;
  logic                     perr_q, perr_d;
  logic                     ferr_q, ferr_d;
  logic                     stop_cnt_q, stop_cnt_d;
  logic                     brk_wait_q, brk_wait_d;

  logic                     sample, last_stop, is_break;
  logic                     push, brk_set, drop;
  rx_entry_t                entry, head;
  logic                     fifo_empty, fifo_full;
  logic [LW-1:0]            fifo_level;
  logic                     overrun_q, break_det_q, rts_n_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      div_cnt_q <= '0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      div_cnt_q <= tick ? cfg_div : div_cnt_q - DIV_W'(1);
    end
  end

  assign tick = (div_cnt_q == '0);

  // The sample counter is zeroed on the start edge, so every bit is sampled near its centre.
  assign sample    = tick && (s_cnt_q == MID_CNT);
  assign last_stop = !stop2_q || stop_cnt_q;
  assign is_break  = !rx_s_q && !stop_cnt_q && (shift_q == '0) && (!par_en_q || !par_bit_q);
  assign aligned   = shift_q >> (4'(MAX_DATA_BITS) - nbits_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      s_cnt_q    <= '0;
      bit_cnt_q  <= '0;
      nbits_q    <= DATA_BITS_DEF;
      shift_q    <= '0;
      stop2_q    <= 1'b0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      par_bit_q  <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      stop_cnt_q <= 1'b0;
      brk_wait_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      s_cnt_q    <= s_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      nbits_q    <= nbits_d;
      shift_q    <= shift_d;
      stop2_q    <= stop2_d;
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
      par_bit_q  <= par_bit_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      stop_cnt_q <= stop_cnt_d;
      brk_wait_q <= brk_wait_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    s_cnt_d    = s_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    nbits_d    = nbits_q;
    shift_d    = shift_q;
    stop2_d    = stop2_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    par_bit_d  = par_bit_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    stop_cnt_d = stop_cnt_q;
    brk_wait_d = brk_wait_q;
    if (tick) s_cnt_d = (s_cnt_q == LAST_CNT) ? '0 : s_cnt_q + SC_W'(1);
    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d    = START;
          s_cnt_d    = '0;
          bit_cnt_d  = '0;
          shift_d    = '0;
          par_bit_d  = 1'b0;
          perr_d     = 1'b0;
          ferr_d     = 1'b0;
          stop_cnt_d = 1'b0;
          brk_wait_d = 1'b0;
          nbits_d    = clamp_data_bits(cfg_data_bits);
          stop2_d    = cfg_stop2;
          par_en_d   = cfg_parity_en;
          par_odd_d  = cfg_parity_odd;
        end
      end
      START: begin
        if (sample) state_d = rx_s_q ? IDLE : DATA;
      end
      DATA: begin
        if (sample) begin
          shift_d   = {rx_s_q, shift_q[MAX_DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == nbits_q - 4'd1) state_d = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (sample) begin
          par_bit_d = rx_s_q;
          perr_d    = ((^shift_q) ^ rx_s_q) != par_odd_q;
          state_d   = STOP;
        end
      end
      STOP: begin
        if (brk_wait_q) begin
          if (rx_s_q) state_d = IDLE;
        end else if (sample) begin
          if (!rx_s_q) ferr_d = 1'b1;
          if (BREAK_EN && is_break) begin
            brk_wait_d = 1'b1;
          end else if (last_stop) begin
            state_d = IDLE;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    push             = 1'b0;
    brk_set          = 1'b0;
    entry.data       = RX_DATA_W'(aligned);
    entry.parity_err = perr_q;
    entry.frame_err  = ferr_q | ~rx_s_q;
    if ((state_q == STOP) && !brk_wait_q && sample) begin
      if (BREAK_EN && is_break) begin
        brk_set = 1'b1;
      end else if (last_stop) begin
        push = 1'b1;
      end
    end
  end

  dti_uart_sync_fifo #(
    .WIDTH ($bits(rx_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (push),
    .wdata_i (entry),
    .pop_i   (rd_en),
    .rdata_o (head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .level_o (fifo_level)
  );

  assign drop = push && fifo_full && !rd_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_q   <= 1'b0;
      break_det_q <= 1'b0;
      rts_n_q     <= 1'b1;
    end else begin
      overrun_q   <= drop ? 1'b1 : (clr_overrun ? 1'b0 : overrun_q);
      break_det_q <= brk_set ? 1'b1 : (clr_overrun ? 1'b0 : break_det_q);
      rts_n_q     <= (fifo_level >= LW'(RTS_THRESH));
    end
  end

  assign rd_data       = MAX_DATA_BITS'(head.data);
  assign rd_parity_err = head.parity_err;
  assign rd_frame_err  = head.frame_err;
  assign empty         = fifo_empty;
  assign full          = fifo_full;
  assign level         = fifo_level;
  assign overrun       = overrun_q;
  assign break_det     = break_det_q;
  assign rts_n         = rts_n_q;

endmodule

// File: tb/tb_dti_uart_rx_core.sv
// Directed self-checking bench for dti_uart_rx_core (cfg_div=3, 16x oversample: 64 clocks per bit).
module tb_dti_uart_rx_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx;
  logic [15:0] cfg_div;
  logic [3:0]  cfg_data_bits;
  logic        cfg_stop2, cfg_parity_en, cfg_parity_odd;
  logic        rd_en, clr_overrun;
  logic [8:0]  rd_data;
  logic        rd_parity_err, rd_frame_err;
  logic        empty, full;
  logic [4:0]  level;
  logic        overrun, break_det, rts_n;

  int tests = 0;
  int fails = 0;
  bit seen;

  always #5 clk = ~clk;

  dti_uart_rx_core dut (
    .clk            (clk),
    .reset          (reset),
    .rx             (rx),
    .cfg_div        (cfg_div),
    .cfg_data_bits  (cfg_data_bits),
    .cfg_stop2      (cfg_stop2),
    .cfg_parity_en  (cfg_parity_en),
    .cfg_parity_odd (cfg_parity_odd),
    .rd_en          (rd_en),
    .clr_overrun    (clr_overrun),
    .rd_data        (rd_data),
    .rd_parity_err  (rd_parity_err),
    .rd_frame_err   (rd_frame_err),
    .empty          (empty),
    .full           (full),
    .level          (level),
    .overrun        (overrun),
    .break_det      (break_det),
    .rts_n          (rts_n)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b, input int clks);
    rx = b;
    repeat (clks) @(negedge clk);
  endtask

  task automatic send_head(input logic [8:0] d, input int nb, input bit pen, input bit pbit);
    drive_bit(1'b0, 64);
    for (int i = 0; i < nb; i++) drive_bit(d[i], 64);
    if (pen) drive_bit(pbit, 64);
  endtask

  // A bad stop bit is held low only through its centre so the line is high again well before
  // the re-triggered start check.
  task automatic send_frame(input logic [8:0] d, input int nb, input bit pen, input bit pbit,
                            input bit stop_ok, input int nstop);
    send_head(d, nb, pen, pbit);
    if (stop_ok) begin
      drive_bit(1'b1, 64 * nstop);
    end else begin
      drive_bit(1'b0, 48);
      drive_bit(1'b1, 16);
    end
  endtask

  task automatic pop();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    rx = 1'b1;
    cfg_div = 16'd3;
    cfg_data_bits = 4'd8;
    cfg_stop2 = 1'b0;
    cfg_parity_en = 1'b0;
    cfg_parity_odd = 1'b0;
    rd_en = 1'b0;
    clr_overrun = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_break_det", 32'(break_det), 32'd0);
    check("rst_rts_n", 32'(rts_n), 32'd1);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_rd_flags", 32'({rd_parity_err, rd_frame_err}), 32'd0);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("idle_rts_n", 32'(rts_n), 32'd0);

    // 8N1 0xA5
    send_frame(9'h0A5, 8, 1'b0, 1'b0, 1'b1, 1);
    check("a5_empty", 32'(empty), 32'd0);
    check("a5_data", 32'(rd_data), 32'h0A5);
    check("a5_perr", 32'(rd_parity_err), 32'd0);
    check("a5_ferr", 32'(rd_frame_err), 32'd0);
    check("a5_level", 32'(level), 32'd1);
    pop();
    check("a5_pop_empty", 32'(empty), 32'd1);
    pop();
    check("pop_when_empty_level", 32'(level), 32'd0);

    // 9E2 0x1F3 (seven ones) with parity driven 0 instead of 1
    cfg_data_bits = 4'd9;
    cfg_parity_en = 1'b1;
    cfg_parity_odd = 1'b0;
    cfg_stop2 = 1'b1;
    send_frame(9'h1F3, 9, 1'b1, 1'b0, 1'b1, 2);
    check("p9_data", 32'(rd_data), 32'h1F3);
    check("p9_perr", 32'(rd_parity_err), 32'd1);
    check("p9_ferr", 32'(rd_frame_err), 32'd0);
    check("p9_level", 32'(level), 32'd1);
    pop();

    // 5O1 0x15 (three ones), correct odd parity bit 0
    cfg_data_bits = 4'd5;
    cfg_parity_odd = 1'b1;
    cfg_stop2 = 1'b0;
    send_frame(9'h015, 5, 1'b1, 1'b0, 1'b1, 1);
    check("p5_data", 32'(rd_data), 32'h015);
    check("p5_perr", 32'(rd_parity_err), 32'd0);
    check("p5_ferr", 32'(rd_frame_err), 32'd0);
    pop();

    // 8N1 0x55 with a low stop bit
    cfg_data_bits = 4'd8;
    cfg_parity_en = 1'b0;
    cfg_parity_odd = 1'b0;
    send_frame(9'h055, 8, 1'b0, 1'b0, 1'b0, 1);
    check("fe_data", 32'(rd_data), 32'h055);
    check("fe_ferr", 32'(rd_frame_err), 32'd1);
    check("fe_perr", 32'(rd_parity_err), 32'd0);
    drive_bit(1'b1, 64);
    check("fe_level", 32'(level), 32'd1);
    pop();

    // All-zero frame with low stop: a break
    send_frame(9'h000, 8, 1'b0, 1'b0, 1'b0, 1);
    drive_bit(1'b1, 64);
`ifdef DTI_UART_RX_BREAK_DET_EN
    check("brk_empty", 32'(empty), 32'd1);
    check("brk_det", 32'(break_det), 32'd1);
    pulse_clr();
    check("brk_clr", 32'(break_det), 32'd0);
`else
    check("brk_empty", 32'(empty), 32'd0);
    check("brk_data", 32'(rd_data), 32'h000);
    check("brk_ferr", 32'(rd_frame_err), 32'd1);
    check("brk_level", 32'(level), 32'd1);
    check("brk_det_tied", 32'(break_det), 32'd0);
    pop();
`endif

    // Fill the FIFO without reading: frames 1..17
    for (int i = 1; i <= 11; i++) send_frame(9'(i), 8, 1'b0, 1'b0, 1'b1, 1);
    check("fill11_level", 32'(level), 32'd11);
    check("fill11_rts_n", 32'(rts_n), 32'd0);
    send_head(9'd12, 8, 1'b0, 1'b0);
    rx = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (!seen && level == 5'd12) begin
        seen = 1'b1;
        check("rts_n_same_cycle", 32'(rts_n), 32'd0);
        @(negedge clk);
        c++;
        check("rts_n_next_cycle", 32'(rts_n), 32'd1);
      end
    end
    check("level_reached_12", 32'(seen), 32'd1);
    for (int i = 13; i <= 16; i++) send_frame(9'(i), 8, 1'b0, 1'b0, 1'b1, 1);
    check("fill16_full", 32'(full), 32'd1);
    check("fill16_level", 32'(level), 32'd16);
    check("fill16_overrun", 32'(overrun), 32'd0);
    send_frame(9'h011, 8, 1'b0, 1'b0, 1'b1, 1);
    check("ovr_set", 32'(overrun), 32'd1);
    check("ovr_level", 32'(level), 32'd16);
    pulse_clr();
    check("ovr_clr", 32'(overrun), 32'd0);
    check("first_head", 32'(rd_data), 32'h001);
    pop();
    check("after_pop_level", 32'(level), 32'd15);
    for (int i = 2; i <= 16; i++) begin
      check($sformatf("drain_%0d", i), 32'(rd_data), 32'(i));
      pop();
    end
    check("drain_empty", 32'(empty), 32'd1);
    @(negedge clk);
    check("drain_rts_n", 32'(rts_n), 32'd0);

    // Short low pulse: false start
    drive_bit(1'b0, 20);
    drive_bit(1'b1, 100);
    check("false_start_empty", 32'(empty), 32'd1);

    // Reset in the middle of a frame
    send_frame(9'h077, 8, 1'b0, 1'b0, 1'b1, 1);
    check("pre_reset_level", 32'(level), 32'd1);
    drive_bit(1'b0, 64);
    drive_bit(1'b1, 64);
    drive_bit(1'b0, 30);
    reset = 1'b1;
    rx = 1'b1;
    @(negedge clk);
    check("midrst_level", 32'(level), 32'd0);
    check("midrst_empty", 32'(empty), 32'd1);
    check("midrst_rts_n", 32'(rts_n), 32'd1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    drive_bit(1'b1, 64);
    cfg_data_bits = 4'd15;
    send_frame(9'h03C, 8, 1'b0, 1'b0, 1'b1, 1);
    check("post_rst_data", 32'(rd_data), 32'h03C);
    check("post_rst_level", 32'(level), 32'd1);
    check("post_rst_flags", 32'({rd_parity_err, rd_frame_err}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
